// File: rtl/input_fifo_pkg.sv
// Shared constants and elaboration helpers for the width-converting input FIFO.
package input_fifo_pkg;

  localparam bit SLICE_LSB_FIRST = 1'b0;
  localparam bit SLICE_MSB_FIRST = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  // Legal: RATIO a power of two in 1..8 dividing IN_WIDTH, DEPTH a power of two >= 2.
  function automatic bit params_ok(input int unsigned in_width, input int unsigned ratio,
                                   input int unsigned depth);
    return is_pow2(ratio) && (ratio <= 8) && (in_width >= ratio) &&
           ((in_width % ratio) == 0) && is_pow2(depth) && (depth >= 2);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM, one write port and one registered read port.
module fifo_ram_sdp import input_fifo_pkg::*; #(
  parameter int unsigned  WIDTH = 16,
  parameter int unsigned  DEPTH = 16,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/input_fifo_wconv.sv
// FWFT FIFO that accepts IN_WIDTH words and emits them as RATIO narrower slices.
module input_fifo_wconv import input_fifo_pkg::*; #(
  parameter int unsigned  IN_WIDTH       = 16,
  parameter int unsigned  RATIO          = 2,
  parameter int unsigned  DEPTH          = 4096,
  parameter int unsigned  PROG_FULL_FREE = 3072,
  parameter bit           MSB_FIRST      = SLICE_LSB_FIRST,
  localparam int unsigned OUT_WIDTH      = IN_WIDTH / RATIO,
  localparam int unsigned CW             = clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 almost_full,
  output logic                 prog_full,
  output logic                 overflow,
  input  logic                 rd_en,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [CW-1:0]        count
);

  localparam int unsigned AW       = CW - 1;
  localparam int unsigned IW       = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam int unsigned PF_LEVEL = (PROG_FULL_FREE >= DEPTH) ? 0 : DEPTH - PROG_FULL_FREE;

  if (!params_ok(IN_WIDTH, RATIO, DEPTH)) begin : g_param_check
    $error("input_fifo_wconv: illegal IN_WIDTH/RATIO/DEPTH combination");
  end

  logic [AW:0]           wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, ram_words;
  logic                  ram_valid, ram_valid_n, ram_rd;
  logic [IN_WIDTH-1:0]   ram_rdata;
  logic [IN_WIDTH-1:0]   out_word, out_word_n;
  logic                  out_valid, out_valid_n, out_load;
  logic [IW-1:0]         slice_idx, slice_idx_n;
  logic                  wr_accept, rd_accept, retire;
  logic [CW-1:0]         count_n;
  logic                  full_n, almost_full_n, prog_full_n, overflow_n;
  logic                  empty_n, almost_empty_n;
  logic [OUT_WIDTH-1:0]  dout_n;

  function automatic logic [OUT_WIDTH-1:0] pick_slice(input logic [IN_WIDTH-1:0] word,
                                                      input logic [IW-1:0]       idx);
    logic [IW-1:0] sel;
    sel = (MSB_FIRST == SLICE_MSB_FIRST) ? IW'(RATIO - 1) - idx : idx;
    return OUT_WIDTH'(word >> (int'(sel) * OUT_WIDTH));
  endfunction

  fifo_ram_sdp #(.WIDTH(IN_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (din),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_rdata)
  );

  // Two-stage prefetch (RAM read register, then output word) keeps reads bubble-free.
  always_comb begin
    wr_accept      = wr_en && !full;
    rd_accept      = rd_en && out_valid;
    retire         = rd_accept && (slice_idx == IW'(RATIO - 1));
    ram_words      = wr_ptr - rd_ptr;
    out_load       = ram_valid && (!out_valid || retire);
    ram_rd         = (ram_words != '0) && (!ram_valid || out_load);

    wr_ptr_n       = wr_accept ? wr_ptr + (AW+1)'(1) : wr_ptr;
    rd_ptr_n       = ram_rd ? rd_ptr + (AW+1)'(1) : rd_ptr;
    ram_valid_n    = ram_rd || (ram_valid && !out_load);
    out_valid_n    = out_load || (out_valid && !retire);
    out_word_n     = out_load ? ram_rdata : out_word;
    slice_idx_n    = slice_idx;
    if (retire)         slice_idx_n = '0;
    else if (rd_accept) slice_idx_n = slice_idx + IW'(1);

    count_n        = count;
    if (wr_accept && !retire)      count_n = count + CW'(1);
    else if (!wr_accept && retire) count_n = count - CW'(1);

    full_n         = (count_n == CW'(DEPTH));
    almost_full_n  = (count_n >= CW'(DEPTH - 1));
    prog_full_n    = (count_n >= CW'(PF_LEVEL));
    overflow_n     = overflow || (wr_en && full);
    empty_n        = !out_valid_n;
    almost_empty_n = !out_valid_n || ((count_n == CW'(1)) && (slice_idx_n == IW'(RATIO - 1)));
    dout_n         = out_valid_n ? pick_slice(out_word_n, slice_idx_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_valid    <= 1'b0;
      out_word     <= '0;
      out_valid    <= 1'b0;
      slice_idx    <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      prog_full    <= (PF_LEVEL == 0);
      overflow     <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      dout         <= '0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      ram_valid    <= ram_valid_n;
      out_word     <= out_word_n;
      out_valid    <= out_valid_n;
      slice_idx    <= slice_idx_n;
      count        <= count_n;
      full         <= full_n;
      almost_full  <= almost_full_n;
      prog_full    <= prog_full_n;
      overflow     <= overflow_n;
      empty        <= empty_n;
      almost_empty <= almost_empty_n;
      dout         <= dout_n;
    end
  end

endmodule
